mem_stage_lsu: RTL and testbench

//   Load/store unit for the MEM stage of the 5-stage RV32IM pipeline. Consumes the
//   EX/MEM outputs (address, store data, funct3) and drives a variable-latency
//   req/ack data bus with byte enables. It returns sign- or zero-extended load data

---
 rtl/mem_stage_lsu.sv | 142 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data bus with byte lanes,
// extends load data and holds the pipeline until the access retires.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_mem,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Busy = 2'd1,
    Done = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic [1:0]       addrLo;
  logic [2:0]       f3q;

  logic             aligned;
  logic [3:0]       reqBe;
  logic [31:0]      reqWdata;
  logic [31:0]      lane;
  logic [31:0]      extData;
  logic             finish;

  // Size decode on funct3[1:0]; 2'b10 and 2'b11 both behave as word.
  always_comb begin
    aligned  = 1'b1;
    reqBe    = 4'b1111;
    reqWdata = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        reqBe    = 4'b0001 << req_addr[1:0];
        reqWdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned  = ~req_addr[0];
        reqBe    = 4'b0011 << {req_addr[1], 1'b0};
        reqWdata = {2{req_wdata[15:0]}};
      end
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  assign lane = bus_rdata >> {addrLo, 3'b000};

  always_comb begin
    extData = bus_rdata;
    unique case (f3q[1:0])
      2'b00: extData = f3q[2] ? {24'b0, lane[7:0]}
                              : {{24{lane[7]}}, lane[7:0]};
      2'b01: extData = f3q[2] ? {16'b0, lane[15:0]}
                              : {{16{lane[15]}}, lane[15:0]};
      default: extData = bus_rdata;
    endcase
  end

  assign finish    = bus_ack || (waitCnt == LastCnt);
  assign stall_mem = ((state == Idle) && req_valid) || (state == Busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= Idle;
      waitCnt   <= '0;
      addrLo    <= '0;
      f3q       <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      load_data <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      done      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      load_data <= '0;
      unique case (state)
        Idle: begin
          if (req_valid && aligned) begin
            state     <= Busy;
            waitCnt   <= '0;
            addrLo    <= req_addr[1:0];
            f3q       <= req_funct3;
            bus_req   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= reqBe;
            bus_wdata <= reqWdata;
          end else if (req_valid) begin
            state    <= Done;
            done     <= 1'b1;
            misalign <= 1'b1;
          end
        end
        Busy: begin
          waitCnt <= waitCnt + 1'b1;
          // An ack on the timeout cycle still completes normally.
          if (finish) begin
            state     <= Done;
            done      <= 1'b1;
            bus_err   <= ~bus_ack;
            load_data <= (bus_ack && !bus_we) ? extData : '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end
        end
        Done:    state <= Idle;
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misalign,
// timeout and reset during a bus cycle.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_mem;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  int          oStalls, oReqCyc, oCyc;
  logic        oDone, oMis, oErr, oWe;
  logic [31:0] oData, oAddr, oWdata;
  logic [3:0]  oBe;

  mem_stage_lsu #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .stall_mem(stall_mem),
    .done(done),
    .load_data(load_data),
    .misalign(misalign),
    .bus_err(bus_err),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Runs one access; ack is raised in BUSY cycle ackAt (0 = never).
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ackAt, input logic [31:0] rdata);
    int busyN;
    busyN = 0;
    oStalls = 0; oReqCyc = 0; oCyc = 1;
    oDone = 0; oMis = 0; oErr = 0; oWe = 0;
    oData = '0; oAddr = '0; oWdata = '0; oBe = '0;
    tick;
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; bus_rdata = rdata;
    smp;
    if (stall_mem) oStalls++;
    for (int i = 0; i < 40 && !oDone; i++) begin
      tick;
      oCyc++;
      bus_ack = 0;
      if (bus_req) begin
        busyN++;
        oReqCyc++;
        bus_ack = (busyN == ackAt);
        if (busyN == 1) begin
          oBe = bus_be; oAddr = bus_addr;
          oWdata = bus_wdata; oWe = bus_we;
        end
      end
      smp;
      if (stall_mem) oStalls++;
      if (done) begin
        oDone = 1; oMis = misalign;
        oErr = bus_err; oData = load_data;
      end
    end
    tick;
    bus_ack = 0;
    req_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1; req_valid = 0; bus_ack = 0;
    tick; tick;
    smp;
    checks++; if (stall_mem !== 1'b0) begin errors++;
      $display("FAIL rst_stall got %b want 0", stall_mem); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", done); end
    checks++; if (bus_req !== 1'b0) begin errors++;
      $display("FAIL rst_req got %b want 0", bus_req); end
    checks++; if (bus_be !== 4'h0) begin errors++;
      $display("FAIL rst_be got %b want 0000", bus_be); end
    checks++; if (load_data !== 32'h0) begin errors++;
      $display("FAIL rst_data got %h want 0", load_data); end
    tick;
    reset = 0;
  endtask

  task automatic test_lw;
    access(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++; if (oBe !== 4'b1111) begin errors++;
      $display("FAIL lw_be got %b want 1111", oBe); end
    checks++; if (oAddr !== 32'h100) begin errors++;
      $display("FAIL lw_addr got %h want 100", oAddr); end
    checks++; if (oWe !== 1'b0) begin errors++;
      $display("FAIL lw_we got %b want 0", oWe); end
    checks++; if (oStalls !== 4) begin errors++;
      $display("FAIL lw_stall got %0d want 4", oStalls); end
    checks++; if (oReqCyc !== 3) begin errors++;
      $display("FAIL lw_reqcyc got %0d want 3", oReqCyc); end
    checks++; if (oDone !== 1'b1) begin errors++;
      $display("FAIL lw_done got %b want 1", oDone); end
    checks++; if (oData !== 32'hDEADBEEF) begin errors++;
      $display("FAIL lw_data got %h want deadbeef", oData); end
    checks++; if ({oMis, oErr} !== 2'b00) begin errors++;
      $display("FAIL lw_flags got %b want 00", {oMis, oErr}); end
    smp;
    checks++; if ({done, bus_req, stall_mem} !== 3'b000) begin errors++;
      $display("FAIL lw_after got %b want 000", {done, bus_req, stall_mem}); end
  endtask

  task automatic test_lb;
    access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80AA5511);
    checks++; if (oBe !== 4'b1000) begin errors++;
      $display("FAIL lb_be got %b want 1000", oBe); end
    checks++; if (oAddr !== 32'h100) begin errors++;
      $display("FAIL lb_addr got %h want 100", oAddr); end
    checks++; if (oStalls !== 2) begin errors++;
      $display("FAIL lb_stall got %0d want 2", oStalls); end
    checks++; if (oData !== 32'hFFFFFF80) begin errors++;
      $display("FAIL lb_data got %h want ffffff80", oData); end
    access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80AA5511);
    checks++; if (oData !== 32'h00000080) begin errors++;
      $display("FAIL lbu_data got %h want 00000080", oData); end
  endtask

  task automatic test_sh;
    access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'hFFFFFFFF);
    checks++; if (oWe !== 1'b1) begin errors++;
      $display("FAIL sh_we got %b want 1", oWe); end
    checks++; if (oBe !== 4'b1100) begin errors++;
      $display("FAIL sh_be got %b want 1100", oBe); end
    checks++; if (oWdata !== 32'hABCDABCD) begin errors++;
      $display("FAIL sh_wdata got %h want abcdabcd", oWdata); end
    checks++; if (oAddr !== 32'h200) begin errors++;
      $display("FAIL sh_addr got %h want 200", oAddr); end
    checks++; if (oData !== 32'h0) begin errors++;
      $display("FAIL sh_data got %h want 0", oData); end
  endtask

  task automatic test_misalign;
    access(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h11111111);
    checks++; if (oReqCyc !== 0) begin errors++;
      $display("FAIL mis_req got %0d want 0", oReqCyc); end
    checks++; if ({oDone, oMis, oErr} !== 3'b110) begin errors++;
      $display("FAIL mis_flags got %b want 110", {oDone, oMis, oErr}); end
    checks++; if (oCyc !== 2) begin errors++;
      $display("FAIL mis_cycle got %0d want 2", oCyc); end
    checks++; if (oStalls !== 1) begin errors++;
      $display("FAIL mis_stall got %0d want 1", oStalls); end
    checks++; if (oData !== 32'h0) begin errors++;
      $display("FAIL mis_data got %h want 0", oData); end
    access(1'b1, 3'b001, 32'h103, 32'h5555, 1, 32'h0);
    checks++; if ({oMis, oReqCyc} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL mis_sh got mis=%b req=%0d want 1/0", oMis, oReqCyc); end
    access(1'b0, 3'b011, 32'h102, 32'h0, 1, 32'h0);
    checks++; if (oMis !== 1'b1) begin errors++;
      $display("FAIL mis_f3_011 got %b want 1", oMis); end
  endtask

  task automatic test_timeout;
    access(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h12345678);
    checks++; if (oReqCyc !== 16) begin errors++;
      $display("FAIL to_reqcyc got %0d want 16", oReqCyc); end
    checks++; if ({oDone, oErr, oMis} !== 3'b110) begin errors++;
      $display("FAIL to_flags got %b want 110", {oDone, oErr, oMis}); end
    checks++; if (oData !== 32'h0) begin errors++;
      $display("FAIL to_data got %h want 0", oData); end
    checks++; if (oCyc !== 18) begin errors++;
      $display("FAIL to_cycle got %0d want 18", oCyc); end
    smp;
    checks++; if ({done, bus_req, stall_mem} !== 3'b000) begin errors++;
      $display("FAIL to_after got %b want 000", {done, bus_req, stall_mem}); end
  endtask

  task automatic test_back_to_back;
    access(1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80AA5511);
    checks++; if (oBe !== 4'b1100) begin errors++;
      $display("FAIL lh_be got %b want 1100", oBe); end
    checks++; if (oData !== 32'hFFFF80AA) begin errors++;
      $display("FAIL lh_data got %h want ffff80aa", oData); end
    access(1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h80AA5511);
    checks++; if (oBe !== 4'b0011) begin errors++;
      $display("FAIL lhu_be got %b want 0011", oBe); end
    checks++; if (oData !== 32'h00005511) begin errors++;
      $display("FAIL lhu_data got %h want 00005511", oData); end
    access(1'b1, 3'b000, 32'h001, 32'hCAFE0077, 1, 32'h0);
    checks++; if ({oBe, oWdata} !== {4'b0010, 32'h77777777}) begin errors++;
      $display("FAIL sb1 got be=%b wd=%h want 0010/77777777", oBe, oWdata); end
  endtask

  task automatic test_reset_mid_busy;
    tick;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010;
    req_addr = 32'h400; bus_rdata = 32'h13572468;
    smp;
    tick;
    smp;
    checks++; if (bus_req !== 1'b1) begin errors++;
      $display("FAIL rmb_busy got %b want 1", bus_req); end
    tick;
    reset = 1;
    smp;
    tick;
    reset = 0; bus_ack = 1; req_valid = 0;
    smp;
    checks++; if ({bus_req, done, stall_mem} !== 3'b000) begin errors++;
      $display("FAIL rmb_out got %b want 000", {bus_req, done, stall_mem}); end
    checks++; if (load_data !== 32'h0) begin errors++;
      $display("FAIL rmb_data got %h want 0", load_data); end
    tick;
    bus_ack = 0;
    smp;
    checks++; if ({bus_req, done} !== 2'b00) begin errors++;
      $display("FAIL rmb_late got %b want 00", {bus_req, done}); end
    access(1'b1, 3'b000, 32'h0, 32'h000000A5, 1, 32'h0);
    checks++; if ({oDone, oWe, oBe} !== {2'b11, 4'b0001}) begin errors++;
      $display("FAIL rmb_sb got %b want 110001", {oDone, oWe, oBe}); end
    checks++; if (oWdata !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL rmb_sb_wd got %h want a5a5a5a5", oWdata); end
  endtask

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bus_ack = 0; bus_rdata = '0;
    test_reset;
    test_lw;
    test_lb;
    test_sh;
    test_misalign;
    test_timeout;
    test_back_to_back;
    test_reset_mid_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
